ieee: RTL and testbench



---
 rtl/ieee_pkg.sv | 17 +
 rtl/ieee_div_core.sv | 56 +++++
 rtl/ieee.sv | 45 ++++
 tb/tb_ieee.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ieee_pkg.sv
// Shared constants for the unsigned-ratio to binary32 converter:
// field widths, exponent bias and the fixed special-case encodings.
package ieee_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   // Dividend is the 5-bit operand scaled by 2^30 so every quotient keeps 26+ significant bits
   localparam int NUM_W  = 35;
   localparam int FRAC_W = 30;

   localparam logic [31:0] QNAN  = 32'h7FC0_0000;
   localparam logic [31:0] PINF  = 32'h7F80_0000;
   localparam logic [31:0] PZERO = 32'h0000_0000;

endpackage

// File: rtl/ieee_div_core.sv
// Combinational core: fixed-point divide, normalise on the leading one and
// round-to-nearest-even into a binary32 word. Only valid for nonzero operands.
module ieee_div_core
   import ieee_pkg::*;
(
   input  logic [4:0]  i_num,
   input  logic [4:0]  i_den,
   output logic [31:0] o_word
);

   logic [NUM_W-1:0]       w_num;
   logic [NUM_W-1:0]       w_den;
   logic [NUM_W-1:0]       w_quo;
   logic [NUM_W-1:0]       w_rem;
   logic [5:0]             w_lead;
   logic [5:0]             w_shift;
   logic [NUM_W-2:0]       w_norm;
   logic [MAN_W-1:0]       w_man;
   logic [EXP_W-1:0]       w_exp;
   logic                   w_guard;
   logic                   w_sticky;
   logic                   w_inc;
   logic [EXP_W+MAN_W-1:0] w_packed;
   logic [EXP_W+MAN_W-1:0] w_rounded;

   assign w_num = {i_num, {FRAC_W{1'b0}}};
   assign w_den = {{(NUM_W-5){1'b0}}, i_den};
   assign w_quo = w_num / w_den;
   assign w_rem = w_num % w_den;

   // Highest set bit wins because later iterations overwrite earlier ones
   always_comb begin
      w_lead = '0;
      for (int i = 0; i < NUM_W; i++) begin
         if (w_quo[i]) begin
            w_lead = 6'(i);
         end
      end
   end

   // Left-justify so the hidden one sits just above the kept bits and drops out
   assign w_shift = 6'(NUM_W - 1) - w_lead;
   assign w_norm  = (NUM_W-1)'(w_quo << w_shift);

   assign w_man    = w_norm[NUM_W-2 -: MAN_W];
   assign w_guard  = w_norm[NUM_W-2-MAN_W];
   assign w_sticky = (|w_norm[NUM_W-3-MAN_W:0]) | (|w_rem);
   assign w_exp    = 8'(w_lead) + 8'(BIAS - FRAC_W);
   assign w_inc    = w_guard & (w_sticky | w_man[0]);

   // A mantissa carry-out ripples straight into the exponent field
   assign w_packed  = {w_exp, w_man};
   assign w_rounded = w_packed + (EXP_W+MAN_W)'(w_inc);
   assign o_word    = {1'b0, w_rounded};

endmodule

// File: rtl/ieee.sv
// Unsigned 5-bit ratio in1/in2 to IEEE-754 binary32, registered with one
// cycle of latency; zero operands map to fixed NaN/inf/zero encodings.
module ieee
   import ieee_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  in1,
   input  logic [4:0]  in2,
   output logic [31:0] out
);

   logic [31:0] w_core;
   logic [31:0] w_next;
   logic [31:0] r_out;

   ieee_div_core u_core (
      .i_num  (in1),
      .i_den  (in2),
      .o_word (w_core)
   );

   // Zero operands bypass the core, whose divide result is meaningless for them
   always_comb begin
      w_next = w_core;
      if (in1 == 5'd0 && in2 == 5'd0) begin
         w_next = QNAN;
      end else if (in2 == 5'd0) begin
         w_next = PINF;
      end else if (in1 == 5'd0) begin
         w_next = PZERO;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= PZERO;
      end else begin
         r_out <= w_next;
      end
   end

   assign out = r_out;

endmodule

// File: tb/tb_ieee.sv
// Scoreboard bench for ieee: stimulus pushes expected words, a monitor
// pops and compares one cycle later; includes an exhaustive operand sweep.
module tb_ieee;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  in1 = 5'd0;
   logic [4:0]  in2 = 5'd0;
   logic [31:0] out;

   int checks = 0;
   int failures = 0;

   logic [31:0] expQ[$];
   string       nameQ[$];

   ieee dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in1   (in1),
      .in2   (in2),
      .out   (out)
   );

   always #5 clk = ~clk;

   // Reference: exponent found with real arithmetic, mantissa rounded with exact integers
   function automatic logic [31:0] refModel(input int a, input int b);
      real         r;
      int          e;
      longint      num;
      longint      m;
      longint      rem;
      logic [7:0]  be;
      logic [63:0] mbits;
      if (a == 0 && b == 0) return 32'h7FC0_0000;
      if (b == 0) return 32'h7F80_0000;
      if (a == 0) return 32'h0000_0000;
      r = real'(a) / real'(b);
      e = -6;
      while (e < 5 && r >= 2.0 ** (e + 1)) e++;
      num = longint'(a) << (23 - e);
      m   = num / longint'(b);
      rem = num % longint'(b);
      mbits = 64'(m);
      if ((2 * rem > longint'(b)) || ((2 * rem == longint'(b)) && mbits[0])) m++;
      if (m == (64'sd1 <<< 24)) begin
         m = 64'sd1 <<< 23;
         e++;
      end
      mbits = 64'(m);
      be = 8'(e + 127);
      return {1'b0, be, mbits[22:0]};
   endfunction

   task automatic checkOutput(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: out=0x%08h expected=0x%08h", nm, got, exp);
      end
   endtask

   task automatic applyStimulus(input int a, input int b, input logic [31:0] exp, input string nm);
      @(negedge clk);
      in1 = 5'(a);
      in2 = 5'(b);
      expQ.push_back(exp);
      nameQ.push_back(nm);
   endtask

   // Monitor: each edge captures exactly the vector queued at the preceding negedge
   initial begin
      logic [31:0] e;
      string       n;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            checkOutput(n, out, e);
         end
      end
   end

   initial begin
      #12;
      checkOutput("reset_state", out, 32'h0000_0000);

      @(negedge clk);
      rst_n = 1'b1;
      expQ.push_back(32'h7FC0_0000);
      nameQ.push_back("reset_release_nan");

      applyStimulus(4, 4, 32'h3F80_0000, "div_4_4");
      applyStimulus(5, 2, 32'h4020_0000, "div_5_2");
      applyStimulus(1, 3, 32'h3EAA_AAAB, "round_up_1_3");
      applyStimulus(1, 31, 32'h3D04_2108, "truncate_1_31");
      applyStimulus(31, 1, 32'h41F8_0000, "max_31_1");
      applyStimulus(0, 7, 32'h0000_0000, "zero_0_7");
      applyStimulus(9, 0, 32'h7F80_0000, "inf_9_0");

      // Mid-cycle input change must not disturb the registered output
      applyStimulus(4, 4, 32'h3F80_0000, "glitch_base");
      @(posedge clk);
      #2;
      in1 = 5'd31;
      in2 = 5'd1;
      #1;
      checkOutput("no_glitch", out, 32'h3F80_0000);

      applyStimulus(4, 4, 32'h3F80_0000, "b2b_4_4");
      applyStimulus(1, 3, 32'h3EAA_AAAB, "b2b_1_3");
      applyStimulus(0, 0, 32'h7FC0_0000, "b2b_0_0");
      applyStimulus(31, 1, 32'h41F8_0000, "b2b_31_1");

      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", out, 32'h0000_0000);
      @(posedge clk);
      #1;
      checkOutput("reset_hold", out, 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      expQ.push_back(32'h41F8_0000);
      nameQ.push_back("post_reset_31_1");

      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            applyStimulus(a, b, refModel(a, b), $sformatf("sweep_%0d_%0d", a, b));
         end
      end

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
